// File: rtl/ram_corrupt_pkg.sv
// Purpose: shared types and defaults for the corrupt-flag RAM controller.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
// Contents: ctrl_state_t (WALK/RUN), DEPTH_DEF/ADDR_W_DEF defaults, addr_in_range().
package ram_corrupt_pkg;

  typedef enum logic {
    WALK = 1'b0,
    RUN  = 1'b1
  } ctrl_state_t;

  localparam int DEPTH_DEF  = 12;
  localparam int ADDR_W_DEF = 4;

  // Addresses are widened to 32 bits by the caller so one helper serves any ADDR_W.
  function automatic logic addr_in_range(input logic [31:0] addr, input logic [31:0] depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/ram_corrupt_ctrl.sv
// Purpose: clear-walk, write arbiter (clear > fill) and registered read port for a DEPTHx1 corrupt-flag RAM.
// Latency: writes reach the RAM port combinationally; read response and addr_err one cycle after acceptance.
// Backpressure: all readies low while walking or on a flush cycle; fill_ready also low while clr_valid is high.
// Ports: clock/reset (async, active-high); flush, busy; fill_* and clr_* write requesters;
//        rd_* request plus rd_resp_* registered response; addr_err; mem_r_* / mem_w_* RAM-side port.
module ram_corrupt_ctrl
  import ram_corrupt_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  output logic              busy,
  input  logic              fill_valid,
  output logic              fill_ready,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic              fill_data,
  input  logic              clr_valid,
  output logic              clr_ready,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_resp_valid,
  output logic              rd_resp_data,
  output logic              addr_err,
  output logic [ADDR_W-1:0] mem_r_addr,
  output logic              mem_r_en,
  input  logic              mem_r_data,
  output logic [ADDR_W-1:0] mem_w_addr,
  output logic              mem_w_en,
  output logic              mem_w_data
);

  ctrl_state_t       state;
  logic [ADDR_W-1:0] walk_cnt;

  logic              run_open;
  logic              clr_acc;
  logic              fill_acc;
  logic              rd_acc;
  logic              wr_acc;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_data;
  logic              wr_in_range;
  logic              rd_in_range;
  logic              rd_data_nxt;

  // A flush cycle accepts nothing, so the walk starts from a quiet RAM port.
  assign run_open   = (state == RUN) && !flush;
  assign clr_ready  = run_open;
  assign fill_ready = run_open && !clr_valid;
  assign rd_ready   = run_open;

  assign clr_acc  = clr_valid && clr_ready;
  assign fill_acc = fill_valid && fill_ready;
  assign rd_acc   = rd_valid && rd_ready;
  assign wr_acc   = clr_acc || fill_acc;

  // clr_acc and fill_acc are mutually exclusive by construction of fill_ready.
  assign wr_addr = clr_acc ? clr_addr : fill_addr;
  assign wr_data = clr_acc ? 1'b0 : fill_data;

  assign wr_in_range = addr_in_range(32'(wr_addr), 32'(DEPTH));
  assign rd_in_range = addr_in_range(32'(rd_addr), 32'(DEPTH));

  always_comb begin
    mem_w_en   = 1'b0;
    mem_w_addr = wr_addr;
    mem_w_data = wr_data;
    if (reset) begin
      mem_w_en = 1'b0;
    end else if (state == WALK) begin
      mem_w_en   = 1'b1;
      mem_w_addr = walk_cnt;
      mem_w_data = 1'b0;
    end else begin
      // Out-of-range writes still handshake but never touch the RAM.
      mem_w_en = wr_acc && wr_in_range;
    end
  end

  assign mem_r_en   = rd_acc;
  assign mem_r_addr = rd_addr;

  // The RAM only commits the write at the clock edge, so a same-cycle write
  // to the read address must be forwarded around the array.
  always_comb begin
    rd_data_nxt = mem_r_data;
    if (!rd_in_range) begin
      rd_data_nxt = 1'b0;
    end else if (wr_acc && wr_in_range && (wr_addr == rd_addr)) begin
      rd_data_nxt = wr_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= WALK;
      walk_cnt      <= '0;
      busy          <= 1'b1;
      rd_resp_valid <= 1'b0;
      rd_resp_data  <= 1'b0;
      addr_err      <= 1'b0;
    end else begin
      rd_resp_valid <= rd_acc;
      addr_err      <= (wr_acc && !wr_in_range) || (rd_acc && !rd_in_range);
      if (rd_acc) begin
        rd_resp_data <= rd_data_nxt;
      end
      case (state)
        WALK: begin
          if (flush) begin
            walk_cnt <= '0;
          end else if (walk_cnt == ADDR_W'(DEPTH - 1)) begin
            walk_cnt <= '0;
            state    <= RUN;
            busy     <= 1'b0;
          end else begin
            walk_cnt <= walk_cnt + ADDR_W'(1);
          end
        end
        RUN: begin
          if (flush) begin
            walk_cnt <= '0;
            state    <= WALK;
            busy     <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_corrupt_ctrl.sv
// Purpose: self-checking bench for ram_corrupt_ctrl plus a 12x1 behavioural corrupt RAM.
// Latency: one stimulus cycle per step; outputs checked 1 time unit after the falling edge.
// Backpressure: readies are predicted by the reference model and compared each cycle.
module tb_ram_corrupt_ctrl;

  localparam int DEPTH  = 12;
  localparam int ADDR_W = 4;

  logic              clock;
  logic              reset;
  logic              flush;
  logic              busy;
  logic              fill_valid;
  logic              fill_ready;
  logic [ADDR_W-1:0] fill_addr;
  logic              fill_data;
  logic              clr_valid;
  logic              clr_ready;
  logic [ADDR_W-1:0] clr_addr;
  logic              rd_valid;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_resp_valid;
  logic              rd_resp_data;
  logic              addr_err;
  logic [ADDR_W-1:0] mem_r_addr;
  logic              mem_r_en;
  logic              mem_r_data;
  logic [ADDR_W-1:0] mem_w_addr;
  logic              mem_w_en;
  logic              mem_w_data;

  ram_corrupt_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .flush        (flush),
    .busy         (busy),
    .fill_valid   (fill_valid),
    .fill_ready   (fill_ready),
    .fill_addr    (fill_addr),
    .fill_data    (fill_data),
    .clr_valid    (clr_valid),
    .clr_ready    (clr_ready),
    .clr_addr     (clr_addr),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_addr      (rd_addr),
    .rd_resp_valid(rd_resp_valid),
    .rd_resp_data (rd_resp_data),
    .addr_err     (addr_err),
    .mem_r_addr   (mem_r_addr),
    .mem_r_en     (mem_r_en),
    .mem_r_data   (mem_r_data),
    .mem_w_addr   (mem_w_addr),
    .mem_w_en     (mem_w_en),
    .mem_w_data   (mem_w_data)
  );

  // Corrupt RAM: reset scribbles all-ones so only the clear walk can zero it.
  logic ram [16];

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) ram[i] <= 1'b1;
    end else if (mem_w_en) begin
      ram[mem_w_addr] <= mem_w_data;
    end
  end

  assign mem_r_data = (mem_r_en && (mem_r_addr < ADDR_W'(DEPTH))) ? ram[mem_r_addr] : 1'bx;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: expected RAM contents, walk progress and pending response.
  bit m_mem [16];
  bit m_walk;
  int m_pos;
  bit m_rv;
  bit m_rd;
  bit m_err;

  task automatic step(input bit rs, input bit fl,
                      input bit fv, input bit [3:0] fa, input bit fd,
                      input bit cv, input bit [3:0] ca,
                      input bit rv, input bit [3:0] ra);
    bit       op;
    bit [3:0] oa;
    bit       od;
    bit       wen;
    @(negedge clock);
    reset      = rs;
    flush      = fl;
    fill_valid = fv;
    fill_addr  = fa;
    fill_data  = fd;
    clr_valid  = cv;
    clr_addr   = ca;
    rd_valid   = rv;
    rd_addr    = ra;
    #1;
    if (rs) begin
      m_walk = 1'b1;
      m_pos  = 0;
      m_rv   = 1'b0;
      m_rd   = 1'b0;
      m_err  = 1'b0;
      for (int i = 0; i < 16; i++) m_mem[i] = 1'b1;
      chk("rst_busy", 32'(busy), 32'd1);
      chk("rst_w_en", 32'(mem_w_en), 32'd0);
      chk("rst_resp_vld", 32'(rd_resp_valid), 32'd0);
      chk("rst_resp_dat", 32'(rd_resp_data), 32'd0);
      chk("rst_addr_err", 32'(addr_err), 32'd0);
      chk("rst_readies", 32'({fill_ready, clr_ready, rd_ready}), 32'd0);
    end else begin
      chk("resp_vld", 32'(rd_resp_valid), 32'(m_rv));
      chk("resp_dat", 32'(rd_resp_data), 32'(m_rd));
      chk("addr_err", 32'(addr_err), 32'(m_err));
      chk("busy", 32'(busy), 32'(m_walk));
      if (m_walk || fl) begin
        chk("readies_off", 32'({fill_ready, clr_ready, rd_ready}), 32'd0);
        chk("r_en_off", 32'(mem_r_en), 32'd0);
        m_rv  = 1'b0;
        m_err = 1'b0;
      end
      if (m_walk) begin
        chk("walk_w_en", 32'(mem_w_en), 32'd1);
        chk("walk_w_addr", 32'(mem_w_addr), 32'(m_pos));
        chk("walk_w_dat", 32'(mem_w_data), 32'd0);
        m_mem[m_pos] = 1'b0;
        if (fl) begin
          m_pos = 0;
        end else begin
          m_pos++;
          if (m_pos == DEPTH) begin
            m_walk = 1'b0;
            m_pos  = 0;
          end
        end
      end else if (fl) begin
        chk("flush_w_en", 32'(mem_w_en), 32'd0);
        m_walk = 1'b1;
        m_pos  = 0;
      end else begin
        chk("clr_rdy", 32'(clr_ready), 32'd1);
        chk("fill_rdy", 32'(fill_ready), 32'(!cv));
        chk("rd_rdy", 32'(rd_ready), 32'd1);
        op  = cv || fv;
        oa  = cv ? ca : fa;
        od  = cv ? 1'b0 : fd;
        wen = op && (oa < DEPTH);
        chk("w_en", 32'(mem_w_en), 32'(wen));
        if (wen) begin
          chk("w_addr", 32'(mem_w_addr), 32'(oa));
          chk("w_dat", 32'(mem_w_data), 32'(od));
        end
        chk("r_en", 32'(mem_r_en), 32'(rv));
        if (rv) chk("r_addr", 32'(mem_r_addr), 32'(ra));
        m_err = (op && (oa >= DEPTH)) || (rv && (ra >= DEPTH));
        m_rv  = rv;
        if (rv) begin
          if (ra >= DEPTH)            m_rd = 1'b0;
          else if (wen && (oa == ra)) m_rd = od;
          else                        m_rd = m_mem[ra];
        end
        if (wen) m_mem[oa] = od;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 4'd0, 0, 0, 4'd0, 0, 4'd0);
  endtask

  task automatic rd(input bit [3:0] a);
    step(0, 0, 0, 4'd0, 0, 0, 4'd0, 1, a);
  endtask

  task automatic fill(input bit [3:0] a, input bit d);
    step(0, 0, 1, a, d, 0, 4'd0, 0, 4'd0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    fill_valid = 1'b0; fill_addr = '0; fill_data = 1'b0;
    clr_valid = 1'b0; clr_addr = '0;
    rd_valid = 1'b0; rd_addr = '0;

    // Power-up walk: 12 busy cycles then reads of every entry.
    step(1, 0, 0, 4'd0, 0, 0, 4'd0, 0, 4'd0);
    step(1, 0, 0, 4'd0, 0, 0, 4'd0, 0, 4'd0);
    idle(13);
    for (int i = 0; i < DEPTH; i++) rd(4'(i));
    idle(1);

    // Fill then read back.
    fill(4'd5, 1'b1);
    rd(4'd5);
    idle(1);

    // Clear beats fill; read of the cleared entry sees the bypassed 0.
    fill(4'd7, 1'b1);
    step(0, 0, 1, 4'd3, 1, 1, 4'd7, 1, 4'd7);
    fill(4'd3, 1'b1);
    rd(4'd3);
    idle(1);

    // Flush, then a second flush at walk position 6.
    fill(4'd2, 1'b1);
    fill(4'd9, 1'b1);
    step(0, 1, 0, 4'd0, 0, 0, 4'd0, 0, 4'd0);
    idle(6);
    step(0, 1, 0, 4'd0, 0, 0, 4'd0, 0, 4'd0);
    idle(13);
    rd(4'd2);
    rd(4'd9);
    idle(1);

    // Out-of-range requests.
    fill(4'd13, 1'b1);
    rd(4'd14);
    idle(2);

    // Reset in the middle of a flush walk.
    fill(4'd4, 1'b1);
    step(0, 1, 0, 4'd0, 0, 0, 4'd0, 0, 4'd0);
    idle(4);
    step(1, 0, 0, 4'd0, 0, 0, 4'd0, 0, 4'd0);
    idle(13);
    for (int i = 0; i < DEPTH; i++) rd(4'(i));

    // Randomized traffic, addresses biased toward the legal range.
    for (int c = 0; c < 3000; c++) begin
      bit       rs, fl, fv, fd, cv, rv;
      bit [3:0] fa, ca, ra;
      rs = ($urandom_range(0, 399) == 0);
      fl = ($urandom_range(0, 59) == 0);
      fv = 1'($urandom_range(0, 1));
      fd = 1'($urandom_range(0, 1));
      cv = ($urandom_range(0, 2) == 0);
      rv = 1'($urandom_range(0, 1));
      fa = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(12, 15)) : 4'($urandom_range(0, 11));
      ca = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(12, 15)) : 4'($urandom_range(0, 11));
      ra = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(12, 15)) : 4'($urandom_range(0, 11));
      step(rs, fl, fv, fa, fd, cv, ca, rv, ra);
    end

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_corrupt_ctrl.md
Name: ram_corrupt_ctrl

Overview:
- Controller and arbiter for a DEPTH-entry x 1-bit corrupt-flag RAM (one async-read port, one posedge write port) used in the LSU/cache refill path.
- After reset, and on every flush request, it walks all entries and writes 0.
- It arbitrates two write requesters: refill-set and clear.
- It serves a registered, single-cycle-latency read port with write-to-read bypass and reports out-of-range addresses.

Parameters:
- DEPTH, 12, number of RAM entries; legal range 2..2**ADDR_W.
- ADDR_W, 4, address width.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  one-cycle pulse; clear all entries.
- busy  out  1  high while an init/flush walk is in progress.
- fill_valid  in  1  set-request valid.
- fill_ready  out  1  set-request accepted this cycle.
- fill_addr  in  ADDR_W  set-request entry.
- fill_data  in  1  value to write.
- clr_valid  in  1  clear-request valid.
- clr_ready  out  1  clear-request accepted this cycle.
- clr_addr  in  ADDR_W  entry to clear (writes 0).
- rd_valid  in  1  read-request valid.
- rd_ready  out  1  read-request accepted.
- rd_addr  in  ADDR_W  read entry.
- rd_resp_valid  out  1  registered read response valid.
- rd_resp_data  out  1  registered read data.
- addr_err  out  1  registered pulse: an accepted request had an address >= DEPTH.
- mem_r_addr  out  ADDR_W  RAM read address.
- mem_r_en  out  1  RAM read enable.
- mem_r_data  in  1  RAM read data (combinational from mem_r_addr).
- mem_w_addr  out  ADDR_W  RAM write address.
- mem_w_en  out  1  RAM write enable.
- mem_w_data  out  1  RAM write data.

Behaviour:
- Reset (async, active-high), register values:
  - state = WALK, walk_cnt = 0, rd_resp_valid = 0, rd_resp_data = 0, addr_err = 0.
  - busy = 1.
  - mem_w_en is forced 0 while reset is high.
- FSM states: WALK, RUN.
- WALK:
  - Each cycle: mem_w_en = 1, mem_w_addr = walk_cnt, mem_w_data = 0; walk_cnt increments.
  - At walk_cnt == DEPTH-1 the next state is RUN, and walk_cnt returns to 0.
  - A full walk takes exactly DEPTH cycles; busy falls in the first RUN cycle.
  - fill_ready, clr_ready and rd_ready are all 0.
- RUN:
  - flush = 1 -> next state WALK with walk_cnt = 0. No request is accepted in the flush cycle: all readies are 0.
  - flush asserted during WALK restarts the walk: walk_cnt = 0 on the next cycle.
- Write arbitration in RUN, fixed priority clear > fill:
  - clr_ready = 1.
  - fill_ready = !clr_valid.
  - At most one RAM write per cycle. The winner drives mem_w_* in the same cycle; write latency is 0 (combinational to the RAM port).
- Read port in RUN:
  - rd_ready = 1; mem_r_en = rd_valid; mem_r_addr = rd_addr.
  - The response is registered: rd_resp_valid = 1 on the cycle after acceptance.
  - Bypass: if the same-cycle accepted write targets rd_addr, rd_resp_data takes the written value, not the RAM data.
- Out-of-range addresses (addr >= DEPTH, e.g. 12..15 at default):
  - Write: accepted (ready handshake completes) but mem_w_en = 0.
  - Read: response data = 0.
  - addr_err pulses for 1 cycle, registered, one cycle after acceptance.
- mem_r_en = 0 whenever no read is accepted, so the RAM drives X. rd_resp_data holds its last value while rd_resp_valid = 0.
- Reset asserted mid-walk or mid-RUN: immediate return to WALK with walk_cnt = 0. Pending responses are dropped (rd_resp_valid = 0).

Decomposition:
- Shared package ram_corrupt_pkg holds:
  - state enum (WALK, RUN);
  - DEPTH/ADDR_W defaults;
  - helper function addr_in_range.
- No sub-module is needed: the arbiter, walk counter and read register live in one module.
- The bench instantiates ram_corrupt_ctrl plus the 12x1 corrupt RAM as the DUT pair.

Test Plan:
1. Reset release, no requests -> busy = 1 for 12 cycles; mem_w_addr steps 0..11 with mem_w_data = 0; busy = 0 on cycle 13; subsequent reads of all entries return 0.
2. RUN, fill_valid with addr 5, data 1, then rd addr 5 next cycle -> fill_ready = 1; rd_resp_valid = 1 with data 1, one cycle after the read is accepted.
3. Same cycle: fill addr 3 data 1, clr addr 7, rd addr 7 -> clr_ready = 1, fill_ready = 0, mem_w_addr = 7; rd_resp_data = 0 via bypass next cycle; fill accepted the following cycle.
4. Set entries 2 and 9 to 1, pulse flush -> readies drop; 12-cycle walk; reads of 2 and 9 return 0; flush pulse at walk cycle 6 extends busy to 6 + 1 + 12 cycles total.
5. fill addr 13 and rd addr 14 -> handshakes complete, mem_w_en = 0, rd_resp_data = 0, addr_err = 1 for one cycle per request.
6. Assert reset during cycle 4 of a flush walk, release -> outputs reset immediately; the walk restarts at addr 0 and completes 12 writes.
